key_filter: RTL and testbench

- Debounce receiver for one mechanical push-button input: the consumer of the bouncing key waveform the testbench key model generates.
- Synchronises the raw key line into the Clk domain and rejects any level change shorter than the filter window.
- Reports each confirmed press and release as a one-cycle flag, plus a stable level.
- Sits between the board key pin and application logic (LED/counter control); one instance per key.

---
 rtl/key_filter_pkg.sv | 19 +
 rtl/key_sync_edge.sv | 37 +++
 rtl/key_filter.sv | 113 +++++++++++
 tb/tb_key_filter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_filter_pkg : shared state encoding and default window sizing      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package key_filter_pkg;

  localparam int CNT_MAX_DEF = 999_999;
  localparam int CNT_W_DEF   = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/key_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_sync_edge : two-flop synchroniser plus edge flop for a key line   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module key_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_s2,
  output logic o_nedge,
  output logic o_pedge
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  // Idle level of a key is high, so all flops come out of reset at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s2_d <= 1'b1;
    end else begin
      r_s1   <= i_key;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign o_s2    = r_s2;
  assign o_nedge = r_s2_d & ~r_s2;
  assign o_pedge = ~r_s2_d & r_s2;

endmodule
`default_nettype wire

// File: rtl/key_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_filter : debounced press/release flag and stable key level       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module key_filter
  import key_filter_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_MAX[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic w_s2;
  logic w_nedge;
  logic w_pedge;
  logic w_fall;
  logic w_rise;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_key_flag;
  logic             w_key_flag_nxt;
  logic             r_key_state;
  logic             w_key_state_nxt;

  key_sync_edge u_sync (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_key   (key_in),
    .o_s2    (w_s2),
    .o_nedge (w_nedge),
    .o_pedge (w_pedge)
  );

  // Edges qualified by the synchronised level they lead to.
  assign w_fall = w_nedge & ~w_s2;
  assign w_rise = w_pedge & w_s2;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_flag  <= 1'b0;
      r_key_state <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_flag  <= w_key_flag_nxt;
      r_key_state <= w_key_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = '0;
    w_key_flag_nxt  = 1'b0;
    w_key_state_nxt = r_key_state;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = FILTER0;
        end
      end
      FILTER0: begin
        // An abort edge beats a completed window in the same cycle.
        if (w_rise) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt     = DOWN;
          w_key_flag_nxt  = 1'b1;
          w_key_state_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      DOWN: begin
        if (w_rise) begin
          w_state_nxt = FILTER1;
        end
      end
      FILTER1: begin
        if (w_fall) begin
          w_state_nxt = DOWN;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt     = IDLE;
          w_key_flag_nxt  = 1'b1;
          w_key_state_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign key_flag  = r_key_flag;
  assign key_state = r_key_state;

endmodule
`default_nettype wire

// File: tb/tb_key_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_filter : directed self-checking bench for key_filter          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_key_filter;
  import key_filter_pkg::*;

  localparam int P_CNT_MAX = 99;
  localparam int P_CNT_W   = 7;

  logic Clk;
  logic Rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;

  int checks;
  int failures;
  int flag_cnt;
  int adj_cnt;
  int bad_state_cnt;
  int base;
  logic prev_flag;
  logic prev_state;

  key_filter #(
    .CNT_MAX (P_CNT_MAX),
    .CNT_W   (P_CNT_W)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Pulse counting, adjacency and "level moves only with a flag" monitors.
  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev_flag  <= 1'b0;
      prev_state <= 1'b1;
    end else begin
      if (key_flag) flag_cnt <= flag_cnt + 1;
      if (key_flag && prev_flag) adj_cnt <= adj_cnt + 1;
      if ((key_state !== prev_state) && !key_flag) bad_state_cnt <= bad_state_cnt + 1;
      prev_flag  <= key_flag;
      prev_state <= key_state;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    flag_cnt      = 0;
    adj_cnt       = 0;
    bad_state_cnt = 0;
    Rst_n         = 1'b0;
    key_in        = 1'b1;

    // 1. Reset values
    steps(5);
    chk("rst_state", int'(key_state), 1);
    chk("rst_flag", int'(key_flag), 0);
    Rst_n = 1'b1;
    steps(5);

    // 1b. Reset asserted mid-FILTER0
    key_in = 1'b0;
    steps(50);
    chk("mid_fsm_filter0", int'(dut.r_state), int'(FILTER0));
    #3 Rst_n = 1'b0;
    #1;
    chk("mid_rst_state", int'(key_state), 1);
    chk("mid_rst_flag", int'(key_flag), 0);
    chk("mid_rst_fsm", int'(dut.r_state), int'(IDLE));
    chk("mid_rst_cnt", int'(dut.r_cnt), 0);
    key_in = 1'b1;
    steps(3);
    Rst_n = 1'b1;
    base = flag_cnt;
    steps(200);
    chk("mid_rst_noflag", flag_cnt - base, 0);

    // 2. Clean press: flag at edge k+102 where k is the s1 sample edge
    key_in = 1'b0;
    base = flag_cnt;
    steps(102);
    chk("press_early", flag_cnt - base, 0);
    chk("press_early_flag", int'(key_flag), 0);
    step();
    chk("press_flag", int'(key_flag), 1);
    chk("press_state", int'(key_state), 0);
    step();
    chk("press_flag_end", int'(key_flag), 0);
    chk("press_state_hold", int'(key_state), 0);
    steps(400);

    // 2b. Clean release, same latency
    key_in = 1'b1;
    base = flag_cnt;
    steps(102);
    chk("rel_early", flag_cnt - base, 0);
    step();
    chk("rel_flag", int'(key_flag), 1);
    chk("rel_state", int'(key_state), 1);
    step();
    chk("rel_flag_end", int'(key_flag), 0);
    steps(100);

    // 4. Glitch from IDLE: 98 cycles low
    base = flag_cnt;
    key_in = 1'b0;
    steps(98);
    key_in = 1'b1;
    steps(200);
    chk("glitch_idle_noflag", flag_cnt - base, 0);
    chk("glitch_idle_fsm", int'(dut.r_state), int'(IDLE));
    chk("glitch_idle_state", int'(key_state), 1);

    // 4b. Glitch from DOWN: 98 cycles high
    key_in = 1'b0;
    steps(200);
    chk("down_entry_state", int'(key_state), 0);
    base = flag_cnt;
    key_in = 1'b1;
    steps(98);
    key_in = 1'b0;
    steps(200);
    chk("glitch_down_noflag", flag_cnt - base, 0);
    chk("glitch_down_fsm", int'(dut.r_state), int'(DOWN));
    chk("glitch_down_state", int'(key_state), 0);
    key_in = 1'b1;
    steps(200);
    chk("down_exit_state", int'(key_state), 1);

    // 5. Boundary: 100 low cycles puts the pedge on the counter==99 cycle
    base = flag_cnt;
    key_in = 1'b0;
    steps(100);
    key_in = 1'b1;
    steps(2);
    chk("bnd_cnt_last", int'(dut.r_cnt), P_CNT_MAX);
    chk("bnd_fsm_f0", int'(dut.r_state), int'(FILTER0));
    step();
    chk("bnd_abort_fsm", int'(dut.r_state), int'(IDLE));
    chk("bnd_abort_flag", int'(key_flag), 0);
    steps(200);
    chk("bnd_abort_noflag", flag_cnt - base, 0);

    // 5b. 101 low cycles: window of exactly 100 stable cycles completes
    key_in = 1'b0;
    steps(101);
    key_in = 1'b1;
    step();
    chk("bnd_ok_early", int'(key_flag), 0);
    step();
    chk("bnd_ok_flag", int'(key_flag), 1);
    chk("bnd_ok_fsm", int'(dut.r_state), int'(DOWN));
    steps(300);
    chk("bnd_ok_pair", flag_cnt - base, 2);
    chk("bnd_ok_state", int'(key_state), 1);

    // 3. Bouncy press and release, gaps 1..95 cycles
    base = flag_cnt;
    for (int i = 0; i < 50; i++) begin
      key_in = ~key_in;
      steps($urandom_range(95, 1));
    end
    chk("bounce_p_noflag", flag_cnt - base, 0);
    key_in = 1'b0;
    steps(500);
    chk("bounce_p_flag", flag_cnt - base, 1);
    chk("bounce_p_state", int'(key_state), 0);
    for (int i = 0; i < 50; i++) begin
      key_in = ~key_in;
      steps($urandom_range(95, 1));
    end
    chk("bounce_r_noflag", flag_cnt - base, 1);
    key_in = 1'b1;
    steps(500);
    chk("bounce_r_flag", flag_cnt - base, 2);
    chk("bounce_r_state", int'(key_state), 1);

    // 6. Back-to-back pairs, each level held 150 cycles
    base = flag_cnt;
    for (int i = 0; i < 4; i++) begin
      key_in = 1'b0;
      steps(150);
      chk("b2b_press_state", int'(key_state), 0);
      key_in = 1'b1;
      steps(150);
      chk("b2b_rel_state", int'(key_state), 1);
    end
    chk("b2b_flags", flag_cnt - base, 8);

    // Global pulse properties
    chk("total_flags", flag_cnt, 16);
    chk("adjacent_flags", adj_cnt, 0);
    chk("state_without_flag", bad_state_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
